// File: rtl/ntt_sched_pkg.sv
// Shared types and defaults for the NTT/INTT engine job scheduler.
package ntt_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CFG   = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_CPL   = 3'd4
    } sched_state_e;

    localparam int DEF_TIMEOUT = 2047;
    localparam int DEF_BANK_W  = 2;
    localparam int DEF_CNT_W   = 12;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ntt_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational search from last_grant+1, pointer advanced by the owner FSM.
module rr_arbiter
    import ntt_sched_pkg::*;
#(
    parameter int NREQ = 2,
    localparam int IDX_W = idx_width(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req_i,
    input  logic             advance_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] cand;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        cand        = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IDX_W'((int'(last_q) + off) % NREQ);
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_idx_o   = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDX_W'(NREQ - 1);
        end else if (advance_i) begin
            last_q <= grant_idx_o;
        end
    end

endmodule

// File: rtl/ntt_job_scheduler.sv
// Shares one pipelined NTT/INTT engine between NREQ requesters, one job at a time,
// with a watchdog that aborts jobs whose engine done never arrives.
module ntt_job_scheduler
    import ntt_sched_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int BANK_W  = DEF_BANK_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_sel,
    input  logic [NREQ*BANK_W-1:0] req_bank,
    output logic [NREQ-1:0]        cpl_valid,
    output logic                   cpl_err,
    output logic                   eng_read_start,
    output logic                   eng_sel,
    output logic                   eng_start,
    output logic                   eng_compu_working,
    input  logic                   eng_done,
    output logic [BANK_W-1:0]      bank_sel,
    output logic [NREQ-1:0]        bank_owner,
    output logic                   busy,
    output logic                   timeout_err,
    input  logic                   err_clr,
    output logic [15:0]            op_count
);

    localparam int IDX_W = idx_width(NREQ);

    sched_state_e      state_q, state_d;
    logic              sel_q, sel_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [NREQ-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]  wd_q, wd_d, wd_inc;
    logic              abort_q, abort_d;
    logic              terr_q, terr_d;
    logic [15:0]       ops_q, ops_d;

    logic [NREQ-1:0]   arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;
    logic              arb_advance;
    logic              pick_sel;
    logic [BANK_W-1:0] pick_bank;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_valid),
        .advance_i   (arb_advance),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .any_o       (arb_any)
    );

    always_comb begin
        pick_sel  = 1'b0;
        pick_bank = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                pick_sel  = req_sel[i];
                pick_bank = req_bank[i*BANK_W +: BANK_W];
            end
        end
    end

    // Saturating watchdog; wd_inc is the RUN-cycle count including the current one.
    assign wd_inc = (wd_q == {CNT_W{1'b1}}) ? wd_q : wd_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        bank_d      = bank_q;
        owner_d     = owner_q;
        wd_d        = wd_q;
        abort_d     = abort_q;
        terr_d      = err_clr ? 1'b0 : terr_q;
        ops_d       = ops_q;
        arb_advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    arb_advance = 1'b1;
                    sel_d       = pick_sel;
                    bank_d      = pick_bank;
                    owner_d     = arb_grant;
                    abort_d     = 1'b0;
                    state_d     = ST_CFG;
                end
            end
            ST_CFG:   state_d = ST_START;
            ST_START: begin
                wd_d    = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                wd_d = wd_inc;
                if (eng_done) begin
                    abort_d = 1'b0;
                    state_d = ST_CPL;
                end else if (wd_inc == CNT_W'(TIMEOUT)) begin
                    // A new timeout outranks a simultaneous err_clr.
                    abort_d = 1'b1;
                    terr_d  = 1'b1;
                    state_d = ST_CPL;
                end
            end
            ST_CPL: begin
                if (!abort_q) ops_d = ops_q + 16'd1;
                owner_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: these are all control/status registers (no storage arrays), so all take the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            bank_q  <= '0;
            owner_q <= '0;
            wd_q    <= '0;
            abort_q <= 1'b0;
            terr_q  <= 1'b0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            bank_q  <= bank_d;
            owner_q <= owner_d;
            wd_q    <= wd_d;
            abort_q <= abort_d;
            terr_q  <= terr_d;
            ops_q   <= ops_d;
        end
    end

    assign req_ready         = (state_q == ST_IDLE) ? arb_grant : '0;
    assign cpl_valid         = (state_q == ST_CPL) ? owner_q : '0;
    assign cpl_err           = (state_q == ST_CPL) && abort_q;
    assign eng_read_start    = (state_q == ST_CFG);
    assign eng_sel           = (state_q == ST_CFG) && sel_q;
    assign eng_start         = (state_q == ST_START);
    assign eng_compu_working = (state_q == ST_START) || (state_q == ST_RUN);
    assign bank_sel          = bank_q;
    assign bank_owner        = owner_q;
    assign busy              = (state_q != ST_IDLE);
    assign timeout_err       = terr_q;
    assign op_count          = ops_q;

endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Self-checking bench: directed and randomized jobs against a transaction-level model.
module tb_ntt_job_scheduler;

    localparam int NREQ      = 2;
    localparam int BANK_W    = 2;
    localparam int W_TIMEOUT = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic [NREQ-1:0]        req_valid, req_sel, req_ready, cpl_valid, bank_owner;
    logic [NREQ*BANK_W-1:0] req_bank;
    logic                   cpl_err, eng_read_start, eng_sel, eng_start, eng_compu_working;
    logic                   eng_done, busy, timeout_err, err_clr;
    logic [BANK_W-1:0]      bank_sel;
    logic [15:0]            op_count;

    logic [NREQ-1:0]        req_valid_w, req_sel_w, req_ready_w, cpl_valid_w, bank_owner_w;
    logic [NREQ*BANK_W-1:0] req_bank_w;
    logic                   cpl_err_w, eng_read_start_w, eng_sel_w, eng_start_w, eng_cw_w;
    logic                   eng_done_w, busy_w, timeout_err_w, err_clr_w;
    logic [BANK_W-1:0]      bank_sel_w;
    logic [15:0]            op_count_w;

    ntt_job_scheduler #(.NREQ(NREQ), .BANK_W(BANK_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_bank(req_bank), .cpl_valid(cpl_valid), .cpl_err(cpl_err),
        .eng_read_start(eng_read_start), .eng_sel(eng_sel), .eng_start(eng_start),
        .eng_compu_working(eng_compu_working), .eng_done(eng_done), .bank_sel(bank_sel),
        .bank_owner(bank_owner), .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr),
        .op_count(op_count)
    );

    ntt_job_scheduler #(.NREQ(NREQ), .BANK_W(BANK_W), .TIMEOUT(W_TIMEOUT)) dut_w (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_w), .req_ready(req_ready_w),
        .req_sel(req_sel_w), .req_bank(req_bank_w), .cpl_valid(cpl_valid_w), .cpl_err(cpl_err_w),
        .eng_read_start(eng_read_start_w), .eng_sel(eng_sel_w), .eng_start(eng_start_w),
        .eng_compu_working(eng_cw_w), .eng_done(eng_done_w), .bank_sel(bank_sel_w),
        .bank_owner(bank_owner_w), .busy(busy_w), .timeout_err(timeout_err_w), .err_clr(err_clr_w),
        .op_count(op_count_w)
    );

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level model state for both instances.
    int m_last, m_ops, m_last_w, m_ops_w;
    bit m_terr_w;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
        logic [NREQ-1:0] t;
        for (int off = 1; off <= NREQ; off++) begin
            t = v >> ((last + off) % NREQ);
            if (t[0]) return (last + off) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last   = NREQ - 1;
        m_ops    = 0;
        m_last_w = NREQ - 1;
        m_ops_w  = 0;
        m_terr_w = 1'b0;
    endtask

    // Full job on the main instance; starts and ends at a negedge with the DUT in IDLE.
    task automatic do_job(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] sel,
                          input logic [NREQ*BANK_W-1:0] bank, input bit hold,
                          input int lat, input bit stray);
        int g;
        logic [NREQ-1:0] oh, ts;
        logic [NREQ*BANK_W-1:0] tb;
        logic [BANK_W-1:0] eb;
        logic es;
        g  = rr_pick(m_last, valid);
        oh = NREQ'(1 << g);
        ts = sel >> g;
        es = ts[0];
        tb = bank >> (g * BANK_W);
        eb = tb[BANK_W-1:0];
        req_valid = valid; req_sel = sel; req_bank = bank; eng_done = stray;
        #1;
        check("grant_ready", req_ready, oh);
        check("idle_busy", busy, 0);
        check("idle_cpl", cpl_valid, 0);
        m_last = g;
        @(negedge clk);
        if (!hold) req_valid = '0;
        req_sel = ~sel; req_bank = ~bank;
        check("cfg_read_start", eng_read_start, 1);
        check("cfg_sel", eng_sel, es);
        check("cfg_bank", bank_sel, eb);
        check("cfg_owner", bank_owner, oh);
        check("cfg_cw", eng_compu_working, 0);
        check("cfg_cpl", cpl_valid, 0);
        eng_done = 1'b0;
        @(negedge clk);
        check("start_pulse", eng_start, 1);
        check("start_cw", eng_compu_working, 1);
        check("start_ready", req_ready, 0);
        @(negedge clk);
        check("run_start_low", eng_start, 0);
        check("run_cw", eng_compu_working, 1);
        for (int k = 1; k < lat; k++) @(negedge clk);
        check("run_bank", bank_sel, eb);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        check("cpl_valid", cpl_valid, oh);
        check("cpl_err", cpl_err, 0);
        check("cpl_cw", eng_compu_working, 0);
        check("cpl_owner", bank_owner, oh);
        check("cpl_ops", op_count, m_ops);
        m_ops = (m_ops + 1) & 16'hFFFF;
        @(negedge clk);
        check("idle_ops", op_count, m_ops);
        check("idle_owner", bank_owner, 0);
        check("idle_bank", bank_sel, eb);
        check("idle_cw", eng_compu_working, 0);
        check("idle_terr", timeout_err, 0);
    endtask

    // Job on the short-watchdog instance; done_at = RUN cycle of eng_done, 0 = never.
    task automatic wd_job(input int done_at, input bit clr);
        bit ok;
        int g;
        ok = (done_at >= 1) && (done_at <= W_TIMEOUT);
        req_valid_w = 2'b01;
        req_sel_w   = NREQ'($urandom);
        req_bank_w  = (NREQ*BANK_W)'($urandom);
        err_clr_w   = clr;
        #1;
        g = rr_pick(m_last_w, req_valid_w);
        check("wd_ready", req_ready_w, NREQ'(1 << g));
        m_last_w = g;
        @(negedge clk);
        req_valid_w = '0;
        @(negedge clk);
        check("wd_start", eng_start_w, 1);
        for (int k = 1; k <= W_TIMEOUT; k++) begin
            @(negedge clk);
            check("wd_run_cw", eng_cw_w, 1);
            if (k == done_at) begin
                eng_done_w = 1'b1;
                break;
            end
        end
        @(negedge clk);
        eng_done_w = 1'b0;
        err_clr_w  = 1'b0;
        if (!ok) m_terr_w = 1'b1;
        else if (clr) m_terr_w = 1'b0;
        check("wd_fall", eng_cw_w, 0);
        check("wd_cpl", cpl_valid_w, NREQ'(1 << g));
        check("wd_cpl_err", cpl_err_w, !ok);
        check("wd_terr", timeout_err_w, m_terr_w);
        check("wd_cpl_ops", op_count_w, m_ops_w);
        if (ok) m_ops_w++;
        @(negedge clk);
        check("wd_idle_ops", op_count_w, m_ops_w);
        check("wd_idle_busy", busy_w, 0);
        check("wd_idle_terr", timeout_err_w, m_terr_w);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_sel = '0; req_bank = '0; eng_done = 1'b0; err_clr = 1'b0;
        req_valid_w = '0; req_sel_w = '0; req_bank_w = '0; eng_done_w = 1'b0; err_clr_w = 1'b0;
        model_reset();
        #1;
        check("rst_busy", busy, 0);
        check("rst_cw", eng_compu_working, 0);
        check("rst_ops", op_count, 0);
        check("rst_owner", bank_owner, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single INTT job from requester 0 on bank 2, done after 1200 RUN cycles.
        do_job(2'b01, 2'b01, 4'b0010, 1'b0, 1200, 1'b0);

        // Stray eng_done while idle.
        eng_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        eng_done = 1'b0;
        check("stray_busy", busy, 0);
        check("stray_cpl", cpl_valid, 0);
        check("stray_ops", op_count, m_ops);

        // Async reset in the middle of RUN.
        req_valid = 2'b10;
        m_last = rr_pick(m_last, req_valid);
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);
        check("pre_rst_cw", eng_compu_working, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_cw", eng_compu_working, 0);
        check("arst_bank", bank_sel, 0);
        check("arst_owner", bank_owner, 0);
        check("arst_ops", op_count, 0);
        check("arst_cpl", cpl_valid, 0);
        model_reset();
        @(negedge clk);
        check("arst_hold_cpl", cpl_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention: both held for three jobs.
        for (int j = 0; j < 3; j++)
            do_job(2'b11, NREQ'($urandom), (NREQ*BANK_W)'($urandom), 1'b1,
                   $urandom_range(1, 20), 1'b0);
        req_valid = '0;
        @(negedge clk);

        // Randomized jobs with stray done pulses in IDLE/CFG.
        for (int j = 0; j < 8; j++)
            do_job(NREQ'($urandom_range(1, 3)), NREQ'($urandom), (NREQ*BANK_W)'($urandom),
                   1'($urandom_range(0, 1)), $urandom_range(1, 30), 1'($urandom_range(0, 1)));
        req_valid = '0;
        @(negedge clk);

        // Watchdog instance: timeout, clear, done-on-timeout, set-beats-clear, normal.
        wd_job(0, 1'b0);
        err_clr_w = 1'b1;
        @(negedge clk);
        err_clr_w = 1'b0;
        m_terr_w = 1'b0;
        check("err_clr", timeout_err_w, m_terr_w);
        wd_job(W_TIMEOUT, 1'b0);
        wd_job(0, 1'b1);
        wd_job($urandom_range(1, W_TIMEOUT - 1), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
